fm_modulate: RTL and testbench
==============================

Name: fm_modulate

Overview:
FM modulator, the transmit-side counterpart of the phase-differencing demodulator. Each signed audio sample is scaled to a phase increment and integrated in a 32-bit phase accumulator. The block emits one AXI-Stream beat per sample in the same packed {angle, magnitude} format the CORDIC and demodulator chain consumes. It sits between the audio source DMA and the polar-to-IQ CORDIC stage.

Parameters:
C_S00_AXIS_TDATA_WIDTH, 32, input stream width; audio sample in [15:0], [31:16] ignored.
C_M00_AXIS_TDATA_WIDTH, 32, output stream width; [31:16] angle, [15:0] magnitude.
DEV_SHIFT, 16, left shift applied to the sign-extended sample to form the deviation increment; legal range 0..16.
AMPLITUDE, 16'h7FFF, constant magnitude placed in output [15:0].

Ports:
s00_axis_aclk  in  1  single clock for the whole block.
s00_axis_aresetn  in  1  asynchronous, active-low reset.
s00_axis_tvalid  in  1  input beat valid.
s00_axis_tready  out  1  input ready.
s00_axis_tdata  in  32  [15:0] signed audio sample.
s00_axis_tstrb  in  4  passed through with the beat.
s00_axis_tlast  in  1  passed through with the beat.
sw  in  4  mode select, sampled on each accepted beat.
freq_word  in  32  carrier/offset phase increment per sample, sampled on each accepted beat.
m00_axis_tready  in  1  downstream ready.
m00_axis_tvalid  out  1  output beat valid.
m00_axis_tdata  out  32  {angle[15:0], AMPLITUDE}.
m00_axis_tstrb  out  4  strobe of the source beat.
m00_axis_tlast  out  1  tlast of the source beat.

Behaviour:
- Reset is asynchronous and active-low. While s00_axis_aresetn=0:
  - phase_acc=0, ramp counter=0, output buffer empty.
  - m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tstrb=0, m00_axis_tlast=0.
  - s00_axis_tready=0.
  - On deassertion, s00_axis_tready rises on the first clock edge.
- Reset mid-packet discards all buffered beats. No partial packet is completed.
- Accept condition: s00_axis_tvalid && s00_axis_tready.
- s00_axis_tready = ~full of the 2-entry output buffer. It is driven from registered state only; there is no combinational path from m00_axis_tready.
- Increment: inc = freq_word + (sext32(sample) << DEV_SHIFT), computed mod 2^32.
- Modes, per accepted beat:
  - sw=0 normal: phase_acc <= phase_acc + inc; angle = phase_acc_next[31:16].
  - sw=1 carrier-only: sample treated as 0.
  - sw=2 bypass: angle = sample; phase_acc unchanged.
  - sw=3 ramp: angle = counter[15:0]; counter increments per accepted beat in every mode; phase_acc unchanged.
  - other sw values behave as sw=0.
- Wrap-around: phase_acc wraps modulo 2^32 with no saturation. 0xFFFF_0000 + 0x0001_0000 gives 0x0000_0000.
- Latency: an accepted beat appears on m00 on the next cycle when the buffer was empty. Beats are emitted strictly in order with tstrb/tlast aligned.
- Buffer rules:
  - Push on accept; pop on m00_axis_tvalid && m00_axis_tready; push and pop in the same cycle are both honoured.
  - m00_axis_tvalid = ~empty; m00 outputs are held stable while tvalid && !tready.
  - With m00_axis_tready held high, throughput is 1 beat/cycle.
  - When full (2 entries), tready=0 and no beat is accepted; tvalid from the source must be held.
- Round-trip property: with DEV_SHIFT=16 and freq_word=0, the demodulator recovers sample>>>1, modulo phase-wrap ambiguity.

Decomposition:
- Package fm_pkg holds:
  - mode constants MODE_NORMAL=0, MODE_CARRIER=1, MODE_BYPASS=2, MODE_RAMP=3;
  - the beat struct typedef {angle, tstrb, tlast};
  - PHASE_W=32 and ANGLE_W=16.
- One sub-module, axis_skid_buffer: a 2-entry AXI-Stream buffer with registered ready, parameterised on payload width.
- fm_modulate instantiates it and owns the phase accumulator, counter and mode logic.

Test Plan:
- Reset, then sw=0, DEV_SHIFT=16, freq_word=0, samples 0x0100 ×4 → angles 0x0100, 0x0200, 0x0300, 0x0400; magnitude 0x7FFF every beat.
- freq_word=0x4000_0000, sample=0, 5 beats → angles 0x4000, 0x8000, 0xC000, 0x0000, 0x4000 (wrap verified).
- sw=2 with sample 0x8001, then sw=0 with sample 0x0001 → first angle 0x8001; second angle 0x0001, proving phase_acc was not advanced in bypass.
- m00_axis_tready=0 while 3 beats are offered → exactly 2 accepted and s00_axis_tready=0; release → 2 beats drained in order, then third accepted; tlast on beat 2 only.
- Random tvalid/tready over 1000 samples in modulator→demodulator loop → demod output equals sample>>>1 for |sample|<0x4000; no beats lost or duplicated.
- Assert aresetn low mid-stream with 2 beats buffered → m00_axis_tvalid=0 immediately (async); after release, first new beat with sample 0x0010 → angle 0x0010.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the FM modulator datapath.
package fm_pkg;

    localparam int PHASE_W = 32;
    localparam int ANGLE_W = 16;
    localparam int STRB_W  = 4;

    localparam logic [3:0] MODE_NORMAL  = 4'd0;
    localparam logic [3:0] MODE_CARRIER = 4'd1;
    localparam logic [3:0] MODE_BYPASS  = 4'd2;
    localparam logic [3:0] MODE_RAMP    = 4'd3;

    // One output beat as it travels through the buffer; magnitude is constant
    // and re-attached at the output, so it is not stored.
    typedef struct packed {
        logic [ANGLE_W-1:0] angle;
        logic [STRB_W-1:0]  tstrb;
        logic               tlast;
    } beat_t;

    // Sign-extend a 16-bit audio sample to phase-accumulator width.
    function automatic logic [PHASE_W-1:0] sext_sample(input logic [ANGLE_W-1:0] s);
        return {{(PHASE_W-ANGLE_W){s[ANGLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer. Upstream ready comes straight from a flop so
// there is no combinational path from downstream ready back to the source.
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data
);

    logic [1:0][DATA_W-1:0] r_mem;
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic                   r_ready;

    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_count_next;

    // Ready is already ~full, so a push can never land on a full buffer.
    assign w_push       = i_s_valid && r_ready;
    assign w_pop        = (r_count != 2'd0) && i_m_ready;
    assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

    assign o_s_ready = r_ready;
    assign o_m_valid = (r_count != 2'd0);
    assign o_m_data  = r_mem[r_rd_ptr];

    // Storage, pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_s_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'd2);
        end
    end

endmodule

// File: rtl/fm_modulate.sv
// FM modulator: integrates scaled audio samples into a phase accumulator and
// emits one {angle, magnitude} beat per accepted sample.
module fm_modulate
    import fm_pkg::*;
#(
    parameter int                 C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int                 C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int                 DEV_SHIFT              = 16,
    parameter logic [ANGLE_W-1:0] AMPLITUDE              = 16'h7FFF
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [STRB_W-1:0]                 s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        sw,
    input  logic [PHASE_W-1:0]                freq_word,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [STRB_W-1:0]                 m00_axis_tstrb,
    output logic                              m00_axis_tlast
);

    logic [PHASE_W-1:0] r_phase_acc;
    logic [PHASE_W-1:0] r_ramp_cnt;

    logic               w_s_ready;
    logic               w_accept;
    logic [ANGLE_W-1:0] w_sample;
    logic [ANGLE_W-1:0] w_eff_sample;
    logic [PHASE_W-1:0] w_inc;
    logic [PHASE_W-1:0] w_acc_sum;
    logic [PHASE_W-1:0] w_acc_next;
    beat_t              w_beat_in;
    beat_t              w_beat_out;
    logic               w_m_valid;
    logic               w_unused_tdata;

    // Upper input lanes carry nothing for this block.
    assign w_unused_tdata = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:ANGLE_W];

    assign w_accept     = s00_axis_tvalid && w_s_ready;
    assign w_sample     = s00_axis_tdata[ANGLE_W-1:0];
    assign w_eff_sample = (sw == MODE_CARRIER) ? '0 : w_sample;
    // Wraps modulo 2^32 by construction; no saturation anywhere.
    assign w_inc        = freq_word + (sext_sample(w_eff_sample) << DEV_SHIFT);
    assign w_acc_sum    = r_phase_acc + w_inc;

    // Mode select: choose the emitted angle and whether the accumulator moves.
    always_comb begin
        w_acc_next      = w_acc_sum;
        w_beat_in.angle = w_acc_sum[PHASE_W-1:PHASE_W-ANGLE_W];
        w_beat_in.tstrb = s00_axis_tstrb;
        w_beat_in.tlast = s00_axis_tlast;
        case (sw)
            MODE_BYPASS: begin
                w_acc_next      = r_phase_acc;
                w_beat_in.angle = w_sample;
            end
            MODE_RAMP: begin
                w_acc_next      = r_phase_acc;
                w_beat_in.angle = r_ramp_cnt[ANGLE_W-1:0];
            end
            default: ;
        endcase
    end

    // Phase accumulator and ramp counter advance only on accepted beats.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_phase_acc <= '0;
            r_ramp_cnt  <= '0;
        end else if (w_accept) begin
            r_phase_acc <= w_acc_next;
            r_ramp_cnt  <= r_ramp_cnt + PHASE_W'(1);
        end
    end

    axis_skid_buffer #(
        .DATA_W($bits(beat_t))
    ) u_buf (
        .clk       (s00_axis_aclk),
        .rst_n     (s00_axis_aresetn),
        .i_s_valid (s00_axis_tvalid),
        .o_s_ready (w_s_ready),
        .i_s_data  (w_beat_in),
        .o_m_valid (w_m_valid),
        .i_m_ready (m00_axis_tready),
        .o_m_data  (w_beat_out)
    );

    // Outputs read as zero whenever no beat is presented (including reset).
    assign s00_axis_tready = w_s_ready;
    assign m00_axis_tvalid = w_m_valid;
    assign m00_axis_tdata  = w_m_valid ? C_M00_AXIS_TDATA_WIDTH'({w_beat_out.angle, AMPLITUDE}) : '0;
    assign m00_axis_tstrb  = w_m_valid ? w_beat_out.tstrb : '0;
    assign m00_axis_tlast  = w_m_valid & w_beat_out.tlast;

endmodule

// File: tb/tb_fm_modulate.sv
module tb_fm_modulate;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [3:0]  s_strb = '0;
    logic        s_last = 1'b0;
    logic [3:0]  sw = '0;
    logic [31:0] freq = '0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        m_last;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] out_data_q[$];
    logic [3:0]  out_strb_q[$];
    logic        out_last_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat that leaves the DUT (transfer completes on next posedge).
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            out_data_q.push_back(m_data);
            out_strb_q.push_back(m_strb);
            out_last_q.push_back(m_last);
        end
    end

    fm_modulate #(.DEV_SHIFT(16)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rstn),
        .s00_axis_tvalid  (s_valid),
        .s00_axis_tready  (s_ready),
        .s00_axis_tdata   (s_data),
        .s00_axis_tstrb   (s_strb),
        .s00_axis_tlast   (s_last),
        .sw               (sw),
        .freq_word        (freq),
        .m00_axis_tready  (m_ready),
        .m00_axis_tvalid  (m_valid),
        .m00_axis_tdata   (m_data),
        .m00_axis_tstrb   (m_strb),
        .m00_axis_tlast   (m_last)
    );

    task automatic clear_q;
        out_data_q.delete();
        out_strb_q.delete();
        out_last_q.delete();
    endtask

    task automatic do_reset;
        s_valid = 1'b0; m_ready = 1'b0; sw = '0; freq = '0;
        s_data = '0; s_strb = '0; s_last = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        clear_q();
        @(posedge clk); #1;
    endtask

    // Offer one beat and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [15:0] smp, input logic [3:0] mode, input logic [31:0] fw,
                        input logic [3:0] strb, input logic last);
        bit ok;
        s_data = {16'hDEAD, smp}; sw = mode; freq = fw; s_strb = strb; s_last = last;
        s_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!ok) begin
            tests_run++; fails++;
            $display("FAIL send_timeout: sample %h not accepted within 200 cycles", smp);
        end
    endtask

    task automatic test_reset;
        s_valid = 1'b0; m_ready = 1'b1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || m_strb !== 4'h0 || m_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b data=%h strb=%h last=%b, required all zero",
                     m_valid, m_data, m_strb, m_last);
        end
        tests_run++;
        if (s_ready !== 1'b0) begin
            fails++; $display("FAIL reset_sready: got %b required 0", s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            fails++; $display("FAIL sready_before_edge: got %b required 0", s_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (s_ready !== 1'b1) begin
            fails++; $display("FAIL sready_first_edge: got %b required 1", s_ready);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_normal;
        logic [15:0] exp_a [4];
        int t0;
        exp_a = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        do_reset();
        m_ready = 1'b1;
        send(16'h0100, 4'd0, 32'h0, 4'hF, 1'b0);
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h0100_7FFF) begin
            fails++;
            $display("FAIL latency: valid=%b data=%h required valid=1 data=01007fff", m_valid, m_data);
        end
        t0 = cyc;
        for (int i = 1; i < 4; i++) send(16'h0100, 4'd0, 32'h0, 4'hF, 1'b0);
        tests_run++;
        if (cyc - t0 != 3) begin
            fails++; $display("FAIL throughput: 3 beats took %0d cycles, required 3", cyc - t0);
        end
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 4) begin
            fails++; $display("FAIL normal_count: got %0d beats required 4", out_data_q.size());
        end
        for (int i = 0; i < 4 && i < out_data_q.size(); i++) begin
            tests_run++;
            if (out_data_q[i] !== {exp_a[i], 16'h7FFF}) begin
                fails++;
                $display("FAIL normal_beat%0d: got %h required %h", i, out_data_q[i], {exp_a[i], 16'h7FFF});
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_a [5];
        exp_a = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(16'h0000, 4'd0, 32'h4000_0000, 4'hF, 1'b0);
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 5) begin
            fails++; $display("FAIL wrap_count: got %0d beats required 5", out_data_q.size());
        end
        for (int i = 0; i < 5 && i < out_data_q.size(); i++) begin
            tests_run++;
            if (out_data_q[i] !== {exp_a[i], 16'h7FFF}) begin
                fails++;
                $display("FAIL wrap_beat%0d: got %h required %h", i, out_data_q[i], {exp_a[i], 16'h7FFF});
            end
        end
    endtask

    task automatic test_bypass;
        do_reset();
        m_ready = 1'b1;
        send(16'h8001, 4'd2, 32'h0, 4'hF, 1'b0);
        send(16'h0001, 4'd0, 32'h0, 4'hF, 1'b0);
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 2) begin
            fails++; $display("FAIL bypass_count: got %0d beats required 2", out_data_q.size());
        end else begin
            tests_run++;
            if (out_data_q[0] !== 32'h8001_7FFF) begin
                fails++; $display("FAIL bypass_angle: got %h required 80017fff", out_data_q[0]);
            end
            tests_run++;
            if (out_data_q[1] !== 32'h0001_7FFF) begin
                fails++; $display("FAIL bypass_acc_hold: got %h required 00017fff", out_data_q[1]);
            end
        end
    endtask

    // Carrier-only, ramp, undefined mode (acts as normal) and a negative sample.
    task automatic test_modes;
        logic [15:0] exp_a [5];
        exp_a = '{16'h0001, 16'h0001, 16'h0011, 16'h0003, 16'h0010};
        do_reset();
        m_ready = 1'b1;
        send(16'h7FFF, 4'd1, 32'h0001_0000, 4'hF, 1'b0);
        send(16'h1234, 4'd3, 32'h0,         4'hF, 1'b0);
        send(16'h0010, 4'd5, 32'h0,         4'hF, 1'b0);
        send(16'h5555, 4'd3, 32'h0,         4'hF, 1'b0);
        send(16'hFFFF, 4'd0, 32'h0,         4'hF, 1'b0);
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 5) begin
            fails++; $display("FAIL modes_count: got %0d beats required 5", out_data_q.size());
        end
        for (int i = 0; i < 5 && i < out_data_q.size(); i++) begin
            tests_run++;
            if (out_data_q[i] !== {exp_a[i], 16'h7FFF}) begin
                fails++;
                $display("FAIL modes_beat%0d: got %h required %h", i, out_data_q[i], {exp_a[i], 16'h7FFF});
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_a [3];
        logic [3:0]  exp_s [3];
        logic        exp_l [3];
        bit acc;
        exp_a = '{16'h0011, 16'h0022, 16'h0033};
        exp_s = '{4'h1, 4'h3, 4'hF};
        exp_l = '{1'b0, 1'b1, 1'b0};
        do_reset();
        m_ready = 1'b0;
        send(16'h0011, 4'd2, 32'h0, 4'h1, 1'b0);
        send(16'h0022, 4'd2, 32'h0, 4'h3, 1'b1);
        s_data = 32'h0000_0033; sw = 4'd2; s_strb = 4'hF; s_last = 1'b0; s_valid = 1'b1;
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            fails++; $display("FAIL full_sready: got %b required 0", s_ready);
        end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h0011_7FFF || m_strb !== 4'h1) begin
            fails++;
            $display("FAIL held_head: valid=%b data=%h strb=%h required 1 00117fff 1", m_valid, m_data, m_strb);
        end
        tests_run++;
        if (out_data_q.size() != 0) begin
            fails++; $display("FAIL stalled_drain: got %0d beats required 0", out_data_q.size());
        end
        m_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                @(posedge clk); #1;
                break;
            end
        end
        s_valid = 1'b0;
        tests_run++;
        if (!acc) begin
            fails++; $display("FAIL third_accept: got not accepted required accepted");
        end
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 3) begin
            fails++; $display("FAIL bp_count: got %0d beats required 3", out_data_q.size());
        end
        for (int i = 0; i < 3 && i < out_data_q.size(); i++) begin
            tests_run++;
            if (out_data_q[i] !== {exp_a[i], 16'h7FFF} || out_strb_q[i] !== exp_s[i] || out_last_q[i] !== exp_l[i]) begin
                fails++;
                $display("FAIL bp_beat%0d: got %h/%h/%b required %h/%h/%b", i, out_data_q[i], out_strb_q[i],
                         out_last_q[i], {exp_a[i], 16'h7FFF}, exp_s[i], exp_l[i]);
            end
        end
    endtask

    // Random handshakes; each beat checked against a running-sum angle model and
    // a phase-difference demodulator that must recover sample>>>1.
    task automatic test_random;
        localparam int N = 1000;
        logic [15:0] smp [N];
        logic [15:0] exp_a [N];
        logic [15:0] sum;
        logic [15:0] prev;
        logic [15:0] diff;
        int idx;
        bit pend;
        bit accepted;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            smp[i]   = 16'($signed($urandom_range(0, 32'h7FFE)) - 32'sd16383);
            sum      = sum + smp[i];
            exp_a[i] = sum;
        end
        do_reset();
        idx = 0; pend = 1'b0;
        for (int c = 0; c < 20000 && out_data_q.size() < N; c++) begin
            m_ready = (idx >= N) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!pend && idx < N && $urandom_range(0, 3) != 0) begin
                s_data = {16'h0, smp[idx]}; sw = 4'd0; freq = '0; s_strb = 4'hF; s_last = 1'b0;
                s_valid = 1'b1; pend = 1'b1;
            end
            @(negedge clk);
            accepted = s_valid && s_ready;
            @(posedge clk); #1;
            if (accepted) begin
                idx++; pend = 1'b0; s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != N) begin
            fails++; $display("FAIL random_count: got %0d beats required %0d", out_data_q.size(), N);
        end
        prev = '0;
        for (int i = 0; i < N && i < out_data_q.size(); i++) begin
            tests_run++;
            if (out_data_q[i] !== {exp_a[i], 16'h7FFF}) begin
                fails++;
                $display("FAIL random_beat%0d: got %h required %h", i, out_data_q[i], {exp_a[i], 16'h7FFF});
            end
            diff = out_data_q[i][31:16] - prev;
            prev = out_data_q[i][31:16];
            tests_run++;
            if (($signed(diff) >>> 1) !== ($signed(smp[i]) >>> 1)) begin
                fails++;
                $display("FAIL demod%0d: got %h required %h", i, 16'($signed(diff) >>> 1), 16'($signed(smp[i]) >>> 1));
            end
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        m_ready = 1'b0;
        send(16'hAAAA, 4'd2, 32'h0, 4'hF, 1'b0);
        send(16'hBBBB, 4'd2, 32'h0, 4'hF, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: valid=%b data=%h sready=%b required 0 00000000 0", m_valid, m_data, s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        clear_q();
        @(posedge clk); #1;
        m_ready = 1'b1;
        send(16'h0010, 4'd0, 32'h0, 4'hF, 1'b0);
        repeat (3) @(posedge clk); #1;
        tests_run++;
        if (out_data_q.size() != 1) begin
            fails++; $display("FAIL post_reset_count: got %0d beats required 1", out_data_q.size());
        end else begin
            tests_run++;
            if (out_data_q[0] !== 32'h0010_7FFF) begin
                fails++; $display("FAIL post_reset_angle: got %h required 00107fff", out_data_q[0]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_wrap();
        test_bypass();
        test_modes();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
